// File: rtl/regfile_pkg.sv
// Shared sizing defaults and register-index constants for the FP register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 16;
  localparam int ONES_REG_DEF = 13;
  localparam int PC_REG_DEF   = NUM_REGS_DEF - 1;

  typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0]           reg_word_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback-side bus of the register file: write ports, reservation, read ports, status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        pc;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     rsv_valid;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W:0]          busy_cnt;
  logic                     wr_conflict;

  modport master (
    output pc, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_valid, rsv_addr, rd_addr,
    input  rsv_ready, rd_data, rd_busy, busy_cnt, wr_conflict
  );

  modport slave (
    input  pc, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_valid, rsv_addr, rd_addr,
    output rsv_ready, rd_data, rd_busy, busy_cnt, wr_conflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending FPU results, with reserve/complete handshake and count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int PC_REG   = PC_REG_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic                rsv_ready,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt
);

  logic [NUM_REGS-1:0] busy_reg, busy_next;
  logic [ADDR_W:0]     cnt_reg, cnt_next;
  logic                rsv_fire;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + {{ADDR_W{1'b0}}, v[i]};
    return n;
  endfunction

  // A completing write frees its register this cycle, so it may be re-reserved at once.
  assign rsv_ready = (rsv_addr != ADDR_W'(PC_REG)) &&
                     (!busy_reg[rsv_addr] || (wb_en && wb_addr == rsv_addr));
  assign rsv_fire  = rsv_valid && rsv_ready;

  always_comb begin
    busy_next = busy_reg;
    if (wb_en)    busy_next[wb_addr]  = 1'b0;
    if (rsv_fire) busy_next[rsv_addr] = 1'b1;
    cnt_next = popcount(busy_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign busy_cnt = cnt_reg;

endmodule

// File: rtl/regfile_sb.sv
// Dual-write, N-read FP register file with write forwarding, PC-mapped top register and scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              NUM_REGS = NUM_REGS_DEF,
  parameter int              NUM_RD   = 2,
  parameter int              PC_REG   = NUM_REGS - 1,
  parameter int              PC_SHIFT = 2,
  parameter int              ONES_REG = ONES_REG_DEF,
  parameter logic [DATA_W-1:0] INIT0  = '0
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_conflict_reg;

  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    if (idx == 0)        return INIT0;
    if (idx == ONES_REG) return {DATA_W{1'b1}};
    return '0;
  endfunction

  // Port B is written last so it overrides port A on a shared address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= reset_value(i);
    end else begin
      if (bus.wa_en && bus.wa_addr != PC_ADDR) regs_reg[bus.wa_addr] <= bus.wa_data;
      if (bus.wb_en && bus.wb_addr != PC_ADDR) regs_reg[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wr_conflict_reg <= 1'b0;
    else if (bus.wa_en && bus.wb_en && bus.wa_addr == bus.wb_addr && bus.wa_addr != PC_ADDR)
      wr_conflict_reg <= 1'b1;
  end

  assign bus.wr_conflict = wr_conflict_reg;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PC_REG   (PC_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (bus.rsv_valid),
    .rsv_addr  (bus.rsv_addr),
    .wb_en     (bus.wb_en),
    .wb_addr   (bus.wb_addr),
    .rsv_ready (bus.rsv_ready),
    .busy      (busy),
    .busy_cnt  (bus.busy_cnt)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

    // A completing FPU result resolves the pending operand; an ALU write does not.
    always_comb begin
      data = regs_reg[addr];
      pend = busy[addr];
      if (addr == PC_ADDR) begin
        data = bus.pc >> PC_SHIFT;
        pend = 1'b0;
      end else if (bus.wb_en && bus.wb_addr == addr) begin
        data = bus.wb_data;
        pend = 1'b0;
      end else if (bus.wa_en && bus.wa_addr == addr) begin
        data = bus.wa_data;
      end
    end

    assign bus.rd_data[gi*DATA_W +: DATA_W] = data;
    assign bus.rd_busy[gi]                  = pend;
  end

endmodule
